sign_narrower: RTL and testbench

Streaming signed narrowing unit: accepts IN_W-bit two's-complement values and emits OUT_W-bit values, performing the inverse of sign extension. It sits on the datapath between the ALU/result bus and halfword-wide consumers such as store-halfword packing and DSP-style result writeback. An overflow is any input not representable in OUT_W bits; each overflow is flagged, counted and, optionally, saturated. Input and output use valid/ready handshakes, and the block is decoupled by a two-entry skid buffer.

---
 rtl/narrow_pkg.sv | 20 ++
 rtl/narrow_core.sv | 26 ++
 rtl/sign_narrower.sv | 108 ++++++++++
 tb/tb_sign_narrower.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/narrow_pkg.sv
// Shared types and default widths for the sign_narrower datapath.
package narrow_pkg;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Beat layout at the default output width.
  typedef struct packed {
    logic                 ovf;
    logic [DEF_OUT_W-1:0] result;
  } beat_t;

endpackage

// File: rtl/narrow_core.sv
// Combinational signed narrowing: overflow detect plus clamp or truncate.
// Clamping is selected by defining SIGN_NARROWER_SATURATE_EN.
module narrow_core #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  numIn,
  output logic [OUT_W-1:0] result,
  output logic             ovf
);

  // Representable only when every bit from the output sign bit upward agrees.
  logic [IN_W-OUT_W:0] upper;
  assign upper = numIn[IN_W-1:OUT_W-1];
  assign ovf   = !((&upper) || (~|upper));

`ifdef SIGN_NARROWER_SATURATE_EN
  logic [OUT_W-1:0] clampVal;
  assign clampVal = numIn[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}};
  assign result   = ovf ? clampVal : numIn[OUT_W-1:0];
`else
  assign result   = numIn[OUT_W-1:0];
`endif

endmodule

// File: rtl/sign_narrower.sv
// Streaming signed narrower with a two-entry skid buffer and overflow statistics.
// Define SIGN_NARROWER_SATURATE_EN to clamp overflowing beats instead of truncating.
module sign_narrower
  import narrow_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [IN_W-1:0]  numIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [OUT_W-1:0] numOut,
  output logic             outOvf,
  output logic             ovfSticky,
  output logic [CNT_W-1:0] ovfCount,
  input  logic             clearOvf
);

  typedef struct packed {
    logic             ovf;
    logic [OUT_W-1:0] result;
  } slot_t;

  state_t stateQ, stateD;
  slot_t  mainQ, skidQ, newBeat;
  logic   inReadyQ;
  logic   loadMain, loadSkid, skidToMain;
  logic   accept, deliver;

  narrow_core #(.IN_W(IN_W), .OUT_W(OUT_W)) uCore (
    .numIn  (numIn),
    .result (newBeat.result),
    .ovf    (newBeat.ovf)
  );

  assign accept   = inValid && inReadyQ;
  assign deliver  = outValid && outReady;
  assign inReady  = inReadyQ;
  assign outValid = (stateQ != EMPTY);
  assign numOut   = mainQ.result;
  assign outOvf   = mainQ.ovf;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    stateD     = stateQ;
    loadMain   = 1'b0;
    loadSkid   = 1'b0;
    skidToMain = 1'b0;
    case (stateQ)
      EMPTY: if (accept) begin
        stateD   = ONE;
        loadMain = 1'b1;
      end
      ONE: begin
        if (accept && deliver) begin
          loadMain = 1'b1;
        end else if (accept) begin
          stateD   = FULL;
          loadSkid = 1'b1;
        end else if (deliver) begin
          stateD = EMPTY;
        end
      end
      FULL: if (deliver) begin
        stateD     = ONE;
        skidToMain = 1'b1;
      end
      default: stateD = EMPTY;
    endcase
  end

  // NOTE: non-blocking assignments for all registered state; the data slots are
  // reset too so numOut/outOvf read as zero out of reset.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      stateQ   <= EMPTY;
      inReadyQ <= 1'b1;
      mainQ    <= '0;
      skidQ    <= '0;
    end else begin
      stateQ   <= stateD;
      inReadyQ <= (stateD != FULL);
      if (loadMain)        mainQ <= newBeat;
      else if (skidToMain) mainQ <= skidQ;
      if (loadSkid)        skidQ <= newBeat;
    end
  end

  // A clear colliding with an overflow beat leaves that beat counted.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      ovfSticky <= 1'b0;
      ovfCount  <= '0;
    end else if (clearOvf) begin
      ovfSticky <= accept && newBeat.ovf;
      ovfCount  <= (accept && newBeat.ovf) ? CNT_W'(1) : '0;
    end else if (accept && newBeat.ovf) begin
      ovfSticky <= 1'b1;
      if (ovfCount != {CNT_W{1'b1}}) ovfCount <= ovfCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sign_narrower.sv
// Scoreboard bench for sign_narrower; build with or without SIGN_NARROWER_SATURATE_EN.
module tb_sign_narrower;
  import narrow_pkg::*;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] numIn = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [15:0] numOut;
  logic        outOvf;
  logic        ovfSticky;
  logic [7:0]  ovfCount;
  logic        clearOvf = 1'b0;

  int checks = 0;
  int errors = 0;
  beat_t sb[$];

  sign_narrower dut (
    .clk(clk), .nReset(nReset), .inValid(inValid), .inReady(inReady),
    .numIn(numIn), .outValid(outValid), .outReady(outReady), .numOut(numOut),
    .outOvf(outOvf), .ovfSticky(ovfSticky), .ovfCount(ovfCount), .clearOvf(clearOvf)
  );

  always #5 clk = ~clk;

  function automatic beat_t model(input logic [31:0] v);
    beat_t b;
    logic [16:0] up;
    up       = v[31:15];
    b.ovf    = !((&up) || (~|up));
    b.result = v[15:0];
`ifdef SIGN_NARROWER_SATURATE_EN
    if (b.ovf) b.result = v[31] ? 16'h8000 : 16'h7FFF;
`endif
    return b;
  endfunction

  // Scoreboard: push on accept, pop and compare on delivery, sampled mid-cycle.
  always @(negedge clk) begin
    if (!nReset) begin
      sb.delete();
    end else begin
      if (outValid && outReady) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got %h/%0b, expected no beat", numOut, outOvf);
        end else begin
          beat_t e;
          e = sb.pop_front();
          if ({outOvf, numOut} !== {e.ovf, e.result}) begin
            errors++;
            $display("FAIL sb_beat: got %h/%0b, expected %h/%0b", numOut, outOvf, e.result, e.ovf);
          end
        end
      end
      if (inValid && inReady) sb.push_back(model(numIn));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    repeat (3) step();
    chk("rst_inReady", 32'(inReady), 32'd1);
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_numOut", 32'(numOut), 32'd0);
    chk("rst_ovfCount", 32'(ovfCount), 32'd0);
    chk("rst_sticky", 32'(ovfSticky), 32'd0);
    nReset = 1'b1;
    repeat (2) step();
    chk("rel_inReady", 32'(inReady), 32'd1);
    chk("rel_outValid", 32'(outValid), 32'd0);
    chk("rel_numOut", 32'(numOut), 32'd0);
  endtask

  task automatic test_passthrough();
    logic [31:0] vin [3] = '{32'h00001234, 32'hFFFF8000, 32'h00007FFF};
    logic [15:0] vout[3] = '{16'h1234, 16'h8000, 16'h7FFF};
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1;
      numIn   = vin[i];
      step();
      chk("pt_valid", 32'(outValid), 32'd1);
      chk("pt_numOut", 32'(numOut), 32'(vout[i]));
      chk("pt_ovf", 32'(outOvf), 32'd0);
    end
    inValid = 1'b0;
    step();
    chk("pt_ovfCount", 32'(ovfCount), 32'd0);
    drain();
  endtask

  task automatic test_overflow();
    logic [31:0] vin[2] = '{32'h00018000, 32'hFFFF7FFF};
`ifdef SIGN_NARROWER_SATURATE_EN
    logic [15:0] vout[2] = '{16'h7FFF, 16'h8000};
`else
    logic [15:0] vout[2] = '{16'h8000, 16'h7FFF};
`endif
    clearOvf = 1'b1;
    step();
    clearOvf = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      inValid = 1'b1;
      numIn   = vin[i];
      step();
      chk("ov_numOut", 32'(numOut), 32'(vout[i]));
      chk("ov_ovf", 32'(outOvf), 32'd1);
    end
    inValid = 1'b0;
    chk("ov_count", 32'(ovfCount), 32'd2);
    chk("ov_sticky", 32'(ovfSticky), 32'd1);
    drain();
  endtask

  task automatic test_backpressure();
    outReady = 1'b0;
    inValid  = 1'b1;
    numIn    = 32'h00000011;
    step();
    chk("bp_ready1", 32'(inReady), 32'd1);
    numIn = 32'h00000022;
    step();
    chk("bp_ready2", 32'(inReady), 32'd0);
    chk("bp_hold", 32'(numOut), 32'h11);
    numIn = 32'h00000033;
    step();
    chk("bp_ready3", 32'(inReady), 32'd0);
    chk("bp_stable", 32'(numOut), 32'h11);
    chk("bp_depth", sb.size(), 32'd2);
    inValid  = 1'b0;
    outReady = 1'b1;
    step();
    chk("bp_reopen", 32'(inReady), 32'd1);
    chk("bp_next", 32'(numOut), 32'h22);
    drain();
  endtask

  task automatic test_clear_sat();
    outReady = 1'b1;
    clearOvf = 1'b1;
    inValid  = 1'b1;
    numIn    = 32'h00018000;
    step();
    clearOvf = 1'b0;
    chk("clr_count", 32'(ovfCount), 32'd1);
    chk("clr_sticky", 32'(ovfSticky), 32'd1);
    for (int i = 0; i < 300; i++) begin
      numIn = (i % 2 == 0) ? 32'h80000000 : 32'h7FFFFFFF;
      step();
    end
    inValid = 1'b0;
    chk("sat_count", 32'(ovfCount), 32'd255);
    drain();
    clearOvf = 1'b1;
    step();
    clearOvf = 1'b0;
    chk("clr2_count", 32'(ovfCount), 32'd0);
    chk("clr2_sticky", 32'(ovfSticky), 32'd0);
  endtask

  task automatic test_midreset();
    outReady = 1'b0;
    inValid  = 1'b1;
    numIn    = 32'h00000AAA;
    step();
    numIn = 32'h00000BBB;
    step();
    inValid = 1'b0;
    chk("mr_full", 32'(inReady), 32'd0);
    nReset = 1'b0;
    #1;
    chk("mr_inReady", 32'(inReady), 32'd1);
    chk("mr_outValid", 32'(outValid), 32'd0);
    chk("mr_numOut", 32'(numOut), 32'd0);
    step();
    nReset = 1'b1;
    step();
    outReady = 1'b1;
    inValid  = 1'b1;
    numIn    = 32'h00000CCC;
    step();
    inValid = 1'b0;
    chk("mr_lat_valid", 32'(outValid), 32'd1);
    chk("mr_lat_data", 32'(numOut), 32'h0CCC);
    step();
    chk("mr_alone", 32'(outValid), 32'd0);
    drain();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_overflow();
    test_backpressure();
    test_clear_sat();
    test_midreset();
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
